// File: rtl/aes128_round_ctrl.sv
// rtl/aes128_round_ctrl.sv - iterative AES-128 round sequencer with key-stall and valid/ready handshakes
// Optional abort input enabled by defining AES_CTRL_ABORT_EN.
module aes128_round_ctrl #(
  parameter int NR    = 10,
  parameter int RND_W = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Start,
  output logic             o_StartRdy,
  input  logic [127:0]     i_Data,
  input  logic             i_fDec,
  output logic [127:0]     o_RoundData,
  output logic [RND_W-1:0] o_Round,
  output logic             o_fFirst,
  output logic             o_fLast,
  output logic             o_fDec,
  input  logic [127:0]     i_RoundData,
  output logic [RND_W-1:0] o_KeyIdx,
  output logic             o_KeyReq,
  input  logic             i_KeyValid,
`ifdef AES_CTRL_ABORT_EN
  input  logic             i_Abort,
`endif
  output logic [127:0]     o_Data,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic             o_Busy
);

  localparam logic [RND_W-1:0] LAST = RND_W'(NR);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           fsm, fsm_nxt;
  logic [127:0]     blk, blk_nxt;
  logic [RND_W-1:0] rnd, rnd_nxt;
  logic             dec, dec_nxt;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      fsm <= ST_IDLE;
      blk <= '0;
      rnd <= '0;
      dec <= 1'b0;
    end else begin
      fsm <= fsm_nxt;
      blk <= blk_nxt;
      rnd <= rnd_nxt;
      dec <= dec_nxt;
    end
  end

  always_comb begin
    fsm_nxt = fsm;
    blk_nxt = blk;
    rnd_nxt = rnd;
    dec_nxt = dec;
    case (fsm)
      ST_IDLE: begin
        if (i_Start) begin
          fsm_nxt = ST_RUN;
          blk_nxt = i_Data;
          dec_nxt = i_fDec;
          rnd_nxt = '0;
        end
      end
      ST_RUN: begin
        // A missing key stalls everything: state and round simply hold.
        if (i_KeyValid) begin
          blk_nxt = i_RoundData;
          if (rnd == LAST) fsm_nxt = ST_DONE;
          else             rnd_nxt = rnd + 1'b1;
        end
      end
      ST_DONE: begin
        if (i_Ready) begin
          fsm_nxt = ST_IDLE;
          rnd_nxt = '0;
        end
      end
      default: fsm_nxt = ST_IDLE;
    endcase
`ifdef AES_CTRL_ABORT_EN
    // Abort overrides key-valid and ready; the partial state is wiped.
    if (i_Abort && (fsm != ST_IDLE)) begin
      fsm_nxt = ST_IDLE;
      blk_nxt = '0;
      rnd_nxt = '0;
    end
`endif
  end

  assign o_StartRdy  = (fsm == ST_IDLE);
  assign o_RoundData = blk;
  assign o_Round     = rnd;
  assign o_fFirst    = (fsm == ST_RUN) && (rnd == '0);
  assign o_fLast     = (fsm == ST_RUN) && (rnd == LAST);
  assign o_fDec      = dec;
  // Decryption walks the key schedule backwards.
  assign o_KeyIdx    = dec ? (LAST - rnd) : rnd;
  assign o_KeyReq    = (fsm == ST_RUN);
  assign o_Data      = blk;
  assign o_Valid     = (fsm == ST_DONE);
  assign o_Busy      = (fsm == ST_RUN) || (fsm == ST_DONE);

endmodule
